// File: rtl/y86_pkg.sv
// y86_pkg: shared icode, status and memory-stage FSM encodings
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/mem_access_decode.sv
// mem_access_decode: maps an icode to its memory access kind, address, write data and static status
module mem_access_decode
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        is_rd,
    output logic        is_wr,
    output logic [63:0] addr,
    output logic [63:0] wdata,
    output logic [1:0]  pre_stat
);
    // stack pops read at the old stack pointer (valA); everything else addresses valE
    always_comb begin
        is_rd    = icode == IMRMOVQ || icode == IPOPQ || icode == IRET;
        is_wr    = icode == IRMMOVQ || icode == IPUSHQ || icode == ICALL;
        addr     = (icode == IPOPQ || icode == IRET) ? valA : valE;
        wdata    = icode == ICALL ? valP : valA;
        pre_stat = icode == IHALT ? STAT_HLT : icode > IPOPQ ? STAT_INS : STAT_AOK;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: Y86-64 memory stage driving a req/gnt/rvalid data-memory handshake
module mem_access_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic [1:0]  stat,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [63:0] LIMIT = 64'(MEM_BYTES - 8);
    logic          is_rd, is_wr;
    logic [63:0]   addr, wdata;
    logic [1:0]    pre_stat;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   valm_q, valm_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]    stat_q, stat_d;
    logic          we_q, we_d;
    mem_access_decode u_dec (
        .icode(icode), .valE(valE), .valA(valA), .valP(valP),
        .is_rd(is_rd), .is_wr(is_wr), .addr(addr), .wdata(wdata), .pre_stat(pre_stat)
    );
    // next state; valM/stat only change on entry to DONE so they hold between dones
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valm_d  = valm_q;
        stat_d  = stat_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: if (start) begin
                if (!(is_rd || is_wr)) begin
                    state_d = S_DONE;
                    stat_d  = pre_stat;
                    valm_d  = '0;
                end else if (addr > LIMIT) begin
                    state_d = S_DONE;
                    stat_d  = STAT_ADR;
                    valm_d  = '0;
                end else begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                    we_d    = is_wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            S_REQ: if (mem_gnt) begin
                state_d = (we_q || mem_rvalid) ? S_DONE : S_WAIT;
                cnt_d   = '0;
                stat_d  = (we_q || mem_rvalid) ? STAT_AOK : stat_q;
                valm_d  = we_q ? '0 : mem_rvalid ? mem_rdata : valm_q;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = S_DONE;
                stat_d  = STAT_ADR;
                valm_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            S_WAIT: if (mem_rvalid) begin
                state_d = S_DONE;
                stat_d  = STAT_AOK;
                valm_d  = mem_rdata;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = S_DONE;
                stat_d  = STAT_ADR;
                valm_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end
    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valm_q  <= '0;
            stat_q  <= STAT_AOK;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valm_q  <= valm_d;
            stat_q  <= stat_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign mem_req   = state_q == S_REQ;
    assign valM      = valm_q;
    assign stat      = stat_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule
